// File: rtl/seg7_scan_driver.sv
// ============================================================================
// Module      : seg7_scan_driver
// Description : Four-digit common-anode 7-segment scanner with per-frame input
//               snapshot, decimal points and whole-display blink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
    parameter int TICK_DIV    = 50000,
    parameter int BLINK_TICKS = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] message0,
    input  logic [4:0] message1,
    input  logic [4:0] message2,
    input  logic [4:0] message3,
    input  logic [3:0] stop_flag,
    input  logic       end_flag,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int c_PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 2;
    localparam int c_BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(TICK_DIV - 1);
    localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_TICKS - 1);
    localparam logic [4:0]      c_BLANK_CODE = 5'h10;

    logic [c_PW-1:0]  r_presc;
    logic             w_tick;
    logic             r_tick_d;
    logic [1:0]       r_idx;
    logic [3:0][4:0]  r_shadow_msg;
    logic [3:0]       r_shadow_stop;
    logic             r_shadow_end;
    logic [c_BW-1:0]  r_blink_cnt;
    logic             r_blink_on;
    logic             w_lit;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic [3:0]       r_an;
    logic             r_frame_tick;
    logic [6:0]       w_seg_dec;

    function automatic logic [6:0] f_decode(input logic [4:0] code);
        logic [6:0] v;
        case (code)
            5'h00: v = 7'h40;
            5'h01: v = 7'h79;
            5'h02: v = 7'h24;
            5'h03: v = 7'h30;
            5'h04: v = 7'h19;
            5'h05: v = 7'h12;
            5'h06: v = 7'h02;
            5'h07: v = 7'h78;
            5'h08: v = 7'h00;
            5'h09: v = 7'h10;
            5'h0A: v = 7'h08;
            5'h0B: v = 7'h03;
            5'h0C: v = 7'h46;
            5'h0D: v = 7'h21;
            5'h0E: v = 7'h06;
            5'h0F: v = 7'h0E;
            5'h11: v = 7'h3F;
            5'h12: v = 7'h09;
            5'h13: v = 7'h47;
            5'h14: v = 7'h0C;
            5'h15: v = 7'h41;
            5'h16: v = 7'h23;
            5'h17: v = 7'h2F;
            default: v = 7'h7F;
        endcase
        return v;
    endfunction

    assign w_tick    = (r_presc == c_PRESC_LAST);
    assign w_seg_dec = f_decode(r_shadow_msg[r_idx]);
    // A freshly cleared end snapshot forces the display on even if the
    // blink phase has not been re-armed yet.
    assign w_lit     = r_blink_on | ~r_shadow_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc  <= '0;
            r_tick_d <= 1'b0;
        end else begin
            r_presc  <= w_tick ? '0 : r_presc + c_PW'(1);
            r_tick_d <= w_tick;
        end
    end

    // Index advance, guard blanking and frame snapshot on the tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx         <= 2'd3;
            r_shadow_msg  <= {4{c_BLANK_CODE}};
            r_shadow_stop <= 4'b0000;
            r_shadow_end  <= 1'b0;
            r_frame_tick  <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            if (w_tick) begin
                r_idx <= r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    r_shadow_msg  <= {message3, message2, message1, message0};
                    r_shadow_stop <= stop_flag;
                    r_shadow_end  <= end_flag;
                    r_frame_tick  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (!r_shadow_end) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (w_tick) begin
            if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + c_BW'(1);
            end
        end
    end

    // Outputs: blank anodes the cycle after a tick, drive the new digit one later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an  <= 4'b1111;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else if (w_tick) begin
            r_an <= 4'b1111;
        end else if (r_tick_d) begin
            r_seg <= w_seg_dec;
            r_dp  <= ~r_shadow_stop[r_idx];
            r_an  <= w_lit ? ~(4'b0001 << r_idx) : 4'b1111;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Directed self-checking bench for seg7_scan_driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

    logic       clk;
    logic       reset;
    logic [4:0] message0, message1, message2, message3;
    logic [3:0] stop_flag;
    logic       end_flag;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_tick;

    int checks   = 0;
    int failures = 0;

    seg7_scan_driver #(
        .TICK_DIV    (4),
        .BLINK_TICKS (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .message0   (message0),
        .message1   (message1),
        .message2   (message2),
        .message3   (message3),
        .stop_flag  (stop_flag),
        .end_flag   (end_flag),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame();
        bit found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) found = 1'b1;
        end
        chk("frame_tick_seen", {31'd0, found}, 32'd1);
    endtask

    // Starts at the frame_tick (guard) sample, ends at the next frame's one.
    task automatic run_frame(input logic [27:0] segs, input logic [3:0] dps,
                             input bit lit, input logic [4:0] m2_mid);
        logic [3:0] exp_an;
        chk("frame_tick", {31'd0, frame_tick}, 32'd1);
        chk("guard_an", {28'd0, an}, 32'hF);
        for (int d = 0; d < 4; d++) begin
            step(1);
            if (d == 1) message2 = m2_mid;
            exp_an = lit ? ~(4'b0001 << d) : 4'b1111;
            chk("an", {28'd0, an}, {28'd0, exp_an});
            chk("seg", {25'd0, seg}, {25'd0, segs[7*d +: 7]});
            chk("dp", {31'd0, dp}, {31'd0, dps[d]});
            step(2);
            chk("an_hold", {28'd0, an}, {28'd0, exp_an});
            step(1);
            chk("guard", {28'd0, an}, 32'hF);
            chk("frame_tick_lvl", {31'd0, frame_tick}, (d == 3) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        reset     = 1'b0;
        message0  = 5'h00;
        message1  = 5'h01;
        message2  = 5'h02;
        message3  = 5'h03;
        stop_flag = 4'b0000;
        end_flag  = 1'b0;
        step(2);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        chk("rst_ft", {31'd0, frame_tick}, 32'd0);
        reset = 1'b1;
        chk("blank_before_frame", {28'd0, an}, 32'hF);

        wait_frame();
        // message2 changes while digit 1 is shown; this frame keeps the old code
        run_frame({7'h30, 7'h24, 7'h79, 7'h40}, 4'b1111, 1'b1, 5'h05);
        message0  = 5'h10;
        stop_flag = 4'b0101;
        run_frame({7'h30, 7'h12, 7'h79, 7'h40}, 4'b1111, 1'b1, 5'h05);
        message0 = 5'h11;
        run_frame({7'h30, 7'h12, 7'h79, 7'h7F}, 4'b1010, 1'b1, 5'h05);
        message0 = 5'h13;
        run_frame({7'h30, 7'h12, 7'h79, 7'h3F}, 4'b1010, 1'b1, 5'h05);
        message0 = 5'h1A;
        run_frame({7'h30, 7'h12, 7'h79, 7'h47}, 4'b1010, 1'b1, 5'h05);
        message0  = 5'h00;
        stop_flag = 4'b0000;
        end_flag  = 1'b1;
        run_frame({7'h30, 7'h12, 7'h79, 7'h7F}, 4'b1010, 1'b1, 5'h05);

        // blink: two frames (8 ticks) lit, two frames off, two lit
        run_frame({7'h30, 7'h12, 7'h79, 7'h40}, 4'b1111, 1'b1, 5'h05);
        run_frame({7'h30, 7'h12, 7'h79, 7'h40}, 4'b1111, 1'b1, 5'h05);
        run_frame({7'h30, 7'h12, 7'h79, 7'h40}, 4'b1111, 1'b0, 5'h05);
        run_frame({7'h30, 7'h12, 7'h79, 7'h40}, 4'b1111, 1'b0, 5'h05);
        run_frame({7'h30, 7'h12, 7'h79, 7'h40}, 4'b1111, 1'b1, 5'h05);
        end_flag = 1'b0;
        run_frame({7'h30, 7'h12, 7'h79, 7'h40}, 4'b1111, 1'b1, 5'h05);
        run_frame({7'h30, 7'h12, 7'h79, 7'h40}, 4'b1111, 1'b1, 5'h05);
        run_frame({7'h30, 7'h12, 7'h79, 7'h40}, 4'b1111, 1'b1, 5'h05);

        // asynchronous reset between clock edges while digit 1 is lit
        step(5);
        chk("pre_reset_an", {28'd0, an}, 32'hD);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_an", {28'd0, an}, 32'hF);
        chk("async_rst_seg", {25'd0, seg}, 32'h7F);
        chk("async_rst_dp", {31'd0, dp}, 32'd1);
        chk("async_rst_ft", {31'd0, frame_tick}, 32'd0);
        step(2);
        reset = 1'b1;
        wait_frame();
        run_frame({7'h30, 7'h12, 7'h79, 7'h40}, 4'b1111, 1'b1, 5'h05);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
